// File: rtl/regfile_wb_arbiter.sv
// Two-port register-file writeback arbiter: port 0 (pipeline) has fixed priority,
// port 1 (multi-cycle unit) is forced through after STARVE_LIMIT denied cycles.
// Optional macro WB_ONEHOT_EN enables the registered one-hot write select.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        valid0,
    input  logic        valid1,
    input  logic [4:0]  addr0,
    input  logic [4:0]  addr1,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    output logic        ready0,
    output logic        ready1,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic [31:0] wr_onehot,
    output logic        force_p1
);

    typedef enum logic [0:0] {
        NORMAL  = 1'b0,
        STARVED = 1'b1
    } state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [2:0]  starve_cnt_q, starve_cnt_d;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic        xfer0_s, xfer1_s;

    // State register for the arbitration FSM and starvation counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= NORMAL;
            starve_cnt_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Output decode: grant signals and starvation indicator
    always_comb begin
        ready0   = 1'b0;
        ready1   = 1'b0;
        force_p1 = 1'b0;
        if (flush) begin
            ready0 = 1'b0;
            ready1 = 1'b0;
        end else begin
            case (state_q)
                NORMAL: begin
                    ready0 = 1'b1;
                    ready1 = valid1 & ~valid0;
                end
                STARVED: begin
                    ready0 = ~valid1;
                    ready1 = 1'b1;
                end
                default: begin
                    ready0 = 1'b0;
                    ready1 = 1'b0;
                end
            endcase
        end
        force_p1 = (state_q == STARVED);
    end

    assign xfer0_s = valid0 & ready0;
    assign xfer1_s = valid1 & ready1;

    // Next-state: counter saturates at the limit; reaching it forces port 1
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        if (flush) begin
            state_d      = NORMAL;
            starve_cnt_d = 3'd0;
        end else begin
            if (!valid1 || xfer1_s) begin
                starve_cnt_d = 3'd0;
            end else if (starve_cnt_q >= LIMIT) begin
                starve_cnt_d = LIMIT;
            end else begin
                starve_cnt_d = starve_cnt_q + 3'd1;
            end
            case (state_q)
                NORMAL: begin
                    if (starve_cnt_d == LIMIT) begin
                        state_d = STARVED;
                    end else begin
                        state_d = NORMAL;
                    end
                end
                STARVED: begin
                    if (xfer1_s || !valid1) begin
                        state_d = NORMAL;
                    end else begin
                        state_d = STARVED;
                    end
                end
                default: begin
                    state_d = NORMAL;
                end
            endcase
        end
    end

    // Write-path next values: capture the winner, hold address/data when idle
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (xfer0_s) begin
            wr_en_d   = (addr0 != 5'd0);
            wr_addr_d = addr0;
            wr_data_d = data0;
        end else if (xfer1_s) begin
            wr_en_d   = (addr1 != 5'd0);
            wr_addr_d = addr1;
            wr_data_d = data1;
        end else begin
            wr_en_d = 1'b0;
        end
    end

    // Write-path registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            wr_data_q <= 32'd0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

`ifdef WB_ONEHOT_EN
    logic [31:0] wr_onehot_q, wr_onehot_d;

    function automatic logic [31:0] decode_onehot(input logic [4:0] a);
        decode_onehot = 32'h1 << a;
    endfunction

    // One-hot select follows wr_en so x0 and idle cycles select nothing
    always_comb begin
        wr_onehot_d = 32'h0;
        if (wr_en_d) begin
            wr_onehot_d = decode_onehot(wr_addr_d);
        end else begin
            wr_onehot_d = 32'h0;
        end
    end

    // One-hot select register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_onehot_q <= 32'h0;
        end else begin
            wr_onehot_q <= wr_onehot_d;
        end
    end

    assign wr_onehot = wr_onehot_q;
`else
    assign wr_onehot = 32'h0;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive denied cycles of port 1 before it is forced; legal range 1..7.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port flush  input  1  synchronous clear of arbitration state and pending write.
REQ-005 SHALL have ports valid0/valid1  input  1 each  writeback request from the pipeline (port 0) and the multi-cycle unit (port 1).
REQ-006 SHALL have ports addr0/addr1  input  5 each  destination register.
REQ-007 SHALL have ports data0/data1  input  32 each  write data.
REQ-008 SHALL have ports ready0/ready1  output  1 each  combinational accept; transfer occurs when valid and ready are both 1.
REQ-009 SHALL have port wr_en  output  1  registered register-file write enable.
REQ-010 SHALL have ports wr_addr (5) and wr_data (32)  output  registered write address and data.
REQ-011 SHALL have port wr_onehot  output  32  registered one-hot write select, bit n set for wr_addr=n.
REQ-012 SHALL have port force_p1  output  1  high while the FSM is in STARVED.

Function
REQ-013 SHALL implement FSM states NORMAL and STARVED, plus a 3-bit saturating counter starve_cnt.
REQ-014 SHALL, in NORMAL, give fixed priority to port 0: ready0=1; ready1 = valid1 and not valid0.
REQ-015 SHALL, in STARVED, give priority to port 1: ready1=1; ready0 = not valid1.
REQ-016 SHALL drive ready0=ready1=0 in any cycle where flush=1.
REQ-017 SHALL increment starve_cnt each cycle with valid1=1 and ready1=0, saturating at STARVE_LIMIT.
REQ-018 SHALL move NORMAL->STARVED on the edge where starve_cnt becomes STARVE_LIMIT.
REQ-019 SHALL move STARVED->NORMAL and clear starve_cnt on any port-1 transfer, or when valid1=0.
REQ-020 SHALL clear starve_cnt in NORMAL whenever valid1=0 or a port-1 transfer occurs.
REQ-021 SHALL register the accepted request with latency 1: wr_addr/wr_data take the winner's values on the next edge.
REQ-022 SHALL set wr_en=1 the cycle after a transfer with addr!=0; wr_en=0 otherwise.
REQ-023 SHALL accept a request with addr=0 normally, but drive wr_en=0 and wr_onehot=0 for it, because x0 is never written.
REQ-024 SHALL grant at most one port per cycle and never drop an accepted request.
REQ-025 SHALL, on flush, return to NORMAL, clear starve_cnt, and drive wr_en=0 and wr_onehot=0 on the next edge.
REQ-026 SHALL hold wr_addr/wr_data unchanged in cycles with no transfer.

Reset
REQ-027 SHALL, while reset=0, asynchronously force: FSM=NORMAL, starve_cnt=0, wr_en=0, wr_addr=0, wr_data=0, wr_onehot=0, force_p1=0.
REQ-028 SHALL discard a request presented in the same cycle that reset is asserted; the first possible transfer is on the first edge after reset=1.

Configuration
REQ-029 SHALL, with macro WB_ONEHOT_EN defined, register wr_onehot per REQ-011/REQ-023.
REQ-030 SHALL, without WB_ONEHOT_EN, tie wr_onehot to 32'h0 and implement no one-hot logic; all other behaviour is unchanged.

Verification
REQ-031 SHALL test: valid0=1, addr0=5, data0=32'hDEADBEEF, valid1=0 -> ready0=1; next cycle wr_en=1, wr_addr=5, wr_onehot=32'h00000020.
REQ-032 SHALL test: valid0 and valid1 both held high, STARVE_LIMIT=4 -> port 0 wins 4 cycles; force_p1=1 in cycle 5, where ready1=1 and ready0=0; then back to NORMAL.
REQ-033 SHALL test: valid1=1, addr1=0, data1=32'h1234 alone -> ready1=1; next cycle wr_en=0, wr_onehot=0.
REQ-034 SHALL test: flush=1 with valid0=1 -> ready0=0; next cycle wr_en=0, starve_cnt=0.
REQ-035 SHALL test: reset asserted mid-stream while in STARVED with wr_en=1 -> immediately wr_en=0, force_p1=0, wr_onehot=0, before any clock edge.
REQ-036 SHALL test: with WB_ONEHOT_EN undefined, rerun the REQ-031 stimulus -> wr_en=1, wr_addr=5, wr_onehot=32'h0.
